// File: rtl/id_stage_sb.sv
// ---------------------------------------------------------------------------
// id_stage_sb -- instruction decode stage with register file, ID/EX pipeline
// register (valid/ready), per-register pending-write scoreboard and in-ID
// resolution of JAL / JR.
//
// Optional feature: define ID_SB_FWD_EN when EX/MEM forwarding exists
// downstream. Only JR source hazards and load-use hazards then stall.
// Without it every source read is checked against the scoreboard.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   if_valid/if_instr/if_pc   instruction from fetch
//   id_ready                  instruction accepted this cycle
//   j_ctrl/j_pc               fetch redirect for an accepted JAL/JR
//   ex_ready/ex_valid         ID/EX handshake
//   ex_p0, ex_p1              operands (ex_p0 = pc+1 for JAL)
//   ex_imm8..ex_hlt, ex_link  decode fields and control to EX
//   wb_we/wb_dst_addr/wb_dst_data  register write-back
//
// Instruction encoding: op[15:12] rd[11:8] rs[7:4] rt[3:0]
//   0000 ADD 0001 SUB 0010 AND 0011 OR : rd = rs op rt
//   0100 SLL 0101 SRL : rd = rs shift rt(shamt)
//   0110 LLB : rd = imm8 (instr[7:0])
//   1000 LW  : rd = mem[rs + imm]     1001 SW : mem[rs + imm] = rd
//   1101 JAL : R[LINK_REG] = pc+1, pc += sext(instr[11:0])
//   1110 JR  : pc = rs                1111 HLT ; others are NOPs
// ---------------------------------------------------------------------------
module id_stage_sb #(
  parameter int DATA_W   = 16,
  parameter int LINK_REG = 15,
  parameter int SB_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  output logic              j_ctrl,
  output logic [DATA_W-1:0] j_pc,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_p0,
  output logic [DATA_W-1:0] ex_p1,
  output logic [7:0]        ex_imm8,
  output logic [3:0]        ex_shamt,
  output logic [2:0]        ex_func,
  output logic              ex_src1sel,
  output logic [3:0]        ex_dst_addr,
  output logic              ex_we_rf,
  output logic              ex_we_mem,
  output logic              ex_re_mem,
  output logic              ex_wb_sel,
  output logic              ex_hlt,
  output logic              ex_link,
  input  logic              wb_we,
  input  logic [3:0]        wb_dst_addr,
  input  logic [DATA_W-1:0] wb_dst_data
);

  localparam logic [3:0]      LINK_A = 4'(LINK_REG);
  localparam logic [SB_W-1:0] SB_MAX = '1;
  localparam logic [SB_W-1:0] SB_ONE = SB_W'(1);

  // ---------------- decode ----------------
  logic [3:0] w_op, w_rd_f, w_rs_f, w_rt_f;
  logic [3:0] w_a0, w_a1, w_dst;
  logic       w_re0, w_re1, w_we_rf, w_we_mem, w_re_mem, w_wb_sel;
  logic       w_hlt, w_jal, w_jr, w_src1sel;
  logic [2:0] w_func;

  assign w_op   = if_instr[15:12];
  assign w_rd_f = if_instr[11:8];
  assign w_rs_f = if_instr[7:4];
  assign w_rt_f = if_instr[3:0];
  assign w_a0   = w_rs_f;

  always_comb begin
    w_re0 = 1'b0; w_re1 = 1'b0; w_we_rf = 1'b0; w_we_mem = 1'b0;
    w_re_mem = 1'b0; w_wb_sel = 1'b0; w_hlt = 1'b0; w_jal = 1'b0;
    w_jr = 1'b0; w_src1sel = 1'b0; w_func = 3'b000;
    w_dst = w_rd_f; w_a1 = w_rt_f;
    case (w_op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        w_re0 = 1'b1; w_re1 = 1'b1; w_we_rf = 1'b1; w_func = w_op[2:0];
      end
      4'b0100, 4'b0101: begin
        w_re0 = 1'b1; w_we_rf = 1'b1; w_func = w_op[2:0];
      end
      4'b0110: begin
        w_we_rf = 1'b1; w_src1sel = 1'b1; w_func = 3'b110;
      end
      4'b1000: begin
        w_re0 = 1'b1; w_we_rf = 1'b1; w_re_mem = 1'b1; w_wb_sel = 1'b1;
        w_src1sel = 1'b1;
      end
      4'b1001: begin
        // store data comes from the rd field
        w_re0 = 1'b1; w_re1 = 1'b1; w_a1 = w_rd_f; w_we_mem = 1'b1;
        w_src1sel = 1'b1; w_dst = 4'd0;
      end
      4'b1101: begin
        w_jal = 1'b1; w_we_rf = 1'b1; w_dst = LINK_A;
      end
      4'b1110: begin
        w_jr = 1'b1; w_re0 = 1'b1; w_dst = 4'd0;
      end
      4'b1111: begin
        w_hlt = 1'b1; w_dst = 4'd0;
      end
      default: w_dst = 4'd0;
    endcase
  end

  // ---------------- register file and scoreboard ----------------
  logic [DATA_W-1:0] w_rf [16];
  logic [SB_W-1:0]   w_sb [16];
  logic              w_issue;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_reg
      logic [DATA_W-1:0] r_val;
      logic [SB_W-1:0]   r_cnt;
      logic              w_wr, w_inc, w_dec;

      assign w_wr  = wb_we && (wb_dst_addr == 4'(gi)) && (gi != 0);
      assign w_inc = w_issue && w_we_rf && (w_dst == 4'(gi)) && (gi != 0);
      // a stray write-back with nothing pending must not underflow
      assign w_dec = w_wr && (r_cnt != '0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_val <= '0;
          r_cnt <= '0;
        end else begin
          if (w_wr) r_val <= wb_dst_data;
          if (w_inc && !w_dec)      r_cnt <= r_cnt + SB_ONE;
          else if (w_dec && !w_inc) r_cnt <= r_cnt - SB_ONE;
        end
      end

      assign w_rf[gi] = r_val;
      assign w_sb[gi] = r_cnt;
    end
  endgenerate

  // read ports with same-cycle write-back bypass
  logic w_byp0, w_byp1;
  logic [DATA_W-1:0] w_rd0, w_rd1;
  assign w_byp0 = wb_we && (wb_dst_addr == w_a0) && (w_a0 != 4'd0);
  assign w_byp1 = wb_we && (wb_dst_addr == w_a1) && (w_a1 != 4'd0);
  assign w_rd0  = w_byp0 ? wb_dst_data : w_rf[w_a0];
  assign w_rd1  = w_byp1 ? wb_dst_data : w_rf[w_a1];

  // ---------------- hazards ----------------
  // A single pending write that lands this cycle is covered by the bypass.
  logic w_haz0, w_haz1, w_full, w_stall;
  assign w_haz0 = w_re0 && (w_a0 != 4'd0) && (w_sb[w_a0] != '0) &&
                  !((w_sb[w_a0] == SB_ONE) && w_byp0);
  assign w_haz1 = w_re1 && (w_a1 != 4'd0) && (w_sb[w_a1] != '0) &&
                  !((w_sb[w_a1] == SB_ONE) && w_byp1);
  // counters never wrap: a writer to a saturated register waits
  assign w_full = w_we_rf && (w_dst != 4'd0) && (w_sb[w_dst] == SB_MAX);

  logic r_ex_valid, r_ex_re_mem, r_halted;
  logic [3:0] r_ex_dst;

`ifdef ID_SB_FWD_EN
  logic w_lu;
  assign w_lu = r_ex_valid && r_ex_re_mem && (r_ex_dst != 4'd0) &&
                ((w_re0 && (w_a0 == r_ex_dst)) || (w_re1 && (w_a1 == r_ex_dst)));
  assign w_stall = (w_jr && w_haz0) || w_lu || w_full;
`else
  assign w_stall = w_haz0 || w_haz1 || w_full;
`endif

  assign id_ready = !rst && !r_halted && !w_stall && (!r_ex_valid || ex_ready);
  assign w_issue  = if_valid && id_ready;
  assign j_ctrl   = w_issue && (w_jal || w_jr);
  assign j_pc     = w_jal ? (if_pc + {{(DATA_W-12){if_instr[11]}}, if_instr[11:0]})
                          : w_rd0;

  // ---------------- ID/EX register ----------------
  logic [DATA_W-1:0] r_ex_p0, r_ex_p1;
  logic [7:0] r_ex_imm8;
  logic [3:0] r_ex_shamt;
  logic [2:0] r_ex_func;
  logic r_ex_src1sel, r_ex_we_rf, r_ex_we_mem, r_ex_wb_sel, r_ex_hlt, r_ex_link;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid <= 1'b0; r_ex_p0 <= '0; r_ex_p1 <= '0; r_ex_imm8 <= '0;
      r_ex_shamt <= '0; r_ex_func <= '0; r_ex_src1sel <= 1'b0; r_ex_dst <= '0;
      r_ex_we_rf <= 1'b0; r_ex_we_mem <= 1'b0; r_ex_re_mem <= 1'b0;
      r_ex_wb_sel <= 1'b0; r_ex_hlt <= 1'b0; r_ex_link <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      // id_ready already implies the slot is free or draining
      if (w_issue) begin
        r_ex_valid   <= 1'b1;
        r_ex_p0      <= w_jal ? (if_pc + DATA_W'(1)) : w_rd0;
        r_ex_p1      <= w_rd1;
        r_ex_imm8    <= if_instr[7:0];
        r_ex_shamt   <= w_rt_f;
        r_ex_func    <= w_func;
        r_ex_src1sel <= w_src1sel;
        r_ex_dst     <= w_dst;
        r_ex_we_rf   <= w_we_rf;
        r_ex_we_mem  <= w_we_mem;
        r_ex_re_mem  <= w_re_mem;
        r_ex_wb_sel  <= w_wb_sel;
        r_ex_hlt     <= w_hlt;
        r_ex_link    <= w_jal;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
      if (w_issue && w_hlt) r_halted <= 1'b1;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_p0       = r_ex_p0;
  assign ex_p1       = r_ex_p1;
  assign ex_imm8     = r_ex_imm8;
  assign ex_shamt    = r_ex_shamt;
  assign ex_func     = r_ex_func;
  assign ex_src1sel  = r_ex_src1sel;
  assign ex_dst_addr = r_ex_dst;
  assign ex_we_rf    = r_ex_we_rf;
  assign ex_we_mem   = r_ex_we_mem;
  assign ex_re_mem   = r_ex_re_mem;
  assign ex_wb_sel   = r_ex_wb_sel;
  assign ex_hlt      = r_ex_hlt;
  assign ex_link     = r_ex_link;

endmodule
